// File: rtl/core_sequencer_if.sv
// Purpose: bundle of core-side control/status signals between the sequencer and the RV32 datapath.
// Latency: n/a (wiring only).
// Backpressure: mem_busy from the memory stage holds the sequencer in MEMORY.
interface core_sequencer_if;
   logic        start;
   logic        halt_req;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic        ex_trap;
   logic [31:0] trap_vector;
   logic        ex_mret;
   logic [31:0] mepc;
   logic        mem_busy;
   logic [31:0] pc;
   logic        fetch_en;
   logic        decode_en;
   logic        execute_en;
   logic        memory_en;
   logic        write_en;
   logic        retire;
   logic        trap_taken;
   logic        fault;
   logic        busy;

   // sequencer side
   modport master (
      input  start, halt_req, ex_branch_taken, ex_branch_target, ex_trap,
             trap_vector, ex_mret, mepc, mem_busy,
      output pc, fetch_en, decode_en, execute_en, memory_en, write_en,
             retire, trap_taken, fault, busy
   );

   // datapath side
   modport slave (
      output start, halt_req, ex_branch_taken, ex_branch_target, ex_trap,
             trap_vector, ex_mret, mepc, mem_busy,
      input  pc, fetch_en, decode_en, execute_en, memory_en, write_en,
             retire, trap_taken, fault, busy
   );
endinterface

// File: rtl/core_sequencer.sv
// Purpose: multi-cycle RV32 control sequencer (F/D/E/M/W strobes, PC and next-PC resolution, mem timeout).
// Latency: 5 cycles per instruction with mem_busy low; each mem_busy cycle adds one.
// Backpressure: mem_busy stalls in MEMORY; MEM_TIMEOUT consecutive busy cycles set sticky fault and go idle.
// Optional: define SEQ_PERF_COUNTERS_EN to add 64-bit cycle_count / instret_count outputs.
module core_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'd0,
   parameter logic [31:0] PC_STEP     = 32'd1,
   parameter int          MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rstn,
   core_sequencer_if.master bus
`ifdef SEQ_PERF_COUNTERS_EN
   ,
   output logic [63:0] cycle_count,
   output logic [63:0] instret_count
`endif
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXECUTE = 3'd3,
      MEMORY  = 3'd4,
      WRITE   = 3'd5
   } state_t;

   // Last counter value before the fault fires: the MEM_TIMEOUT-th busy cycle trips it.
   localparam logic [15:0] CNT_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      state;
   state_t      state_nx;
   logic [31:0] pc_q;
   logic [31:0] next_pc;
   logic        trap_pending;
   logic        fault_q;
   logic [15:0] mem_cnt;
   logic        timeout_hit;

   assign timeout_hit = bus.mem_busy && (mem_cnt == CNT_LAST);

   assign bus.pc         = pc_q;
   assign bus.fault      = fault_q;
   assign bus.busy       = (state != IDLE);
   assign bus.fetch_en   = (state == FETCH);
   assign bus.decode_en  = (state == DECODE);
   assign bus.execute_en = (state == EXECUTE);
   assign bus.memory_en  = (state == MEMORY);
   assign bus.write_en   = (state == WRITE);
   assign bus.retire     = (state == WRITE);
   assign bus.trap_taken = (state == WRITE) && trap_pending;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state decode; halt_req only matters in WRITE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = FETCH;
         FETCH:   state_nx = DECODE;
         DECODE:  state_nx = EXECUTE;
         EXECUTE: state_nx = MEMORY;
         MEMORY: begin
            if (!bus.mem_busy)   state_nx = WRITE;
            else if (timeout_hit) state_nx = IDLE;
         end
         WRITE:   state_nx = bus.halt_req ? IDLE : FETCH;
         default: state_nx = IDLE;
      endcase
   end

   // PC, redirect resolution, trap flag, stall counter and sticky fault.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q         <= RESET_PC;
         next_pc      <= RESET_PC;
         trap_pending <= 1'b0;
         fault_q      <= 1'b0;
         mem_cnt      <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) fault_q <= 1'b0;
            end
            EXECUTE: begin
               trap_pending <= bus.ex_trap;
               if (bus.ex_trap)              next_pc <= bus.trap_vector;
               else if (bus.ex_mret)         next_pc <= bus.mepc;
               else if (bus.ex_branch_taken) next_pc <= bus.ex_branch_target;
               else                          next_pc <= pc_q + PC_STEP;
            end
            MEMORY: begin
               if (!bus.mem_busy) begin
                  mem_cnt <= 16'd0;
               end else if (timeout_hit) begin
                  // pc stays on the faulting instruction so a restart refetches it
                  fault_q <= 1'b1;
                  mem_cnt <= 16'd0;
               end else begin
                  mem_cnt <= mem_cnt + 16'd1;
               end
            end
            WRITE: begin
               pc_q <= next_pc;
            end
            default: ;
         endcase
      end
   end

`ifdef SEQ_PERF_COUNTERS_EN
   // Performance counters: busy cycles and retired instructions, free-running with wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_count   <= 64'd0;
         instret_count <= 64'd0;
      end else begin
         if (state != IDLE)  cycle_count   <= cycle_count + 64'd1;
         if (state == WRITE) instret_count <= instret_count + 64'd1;
      end
   end
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Purpose: directed self-checking bench for core_sequencer (table of per-instruction vectors plus hand sequences).
// Latency: n/a.
// Backpressure: mem_busy driven per vector; timeout exercised by hand.
module tb_core_sequencer;

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_err;

   core_sequencer_if bus_if ();

`ifdef SEQ_PERF_COUNTERS_EN
   logic [63:0] cycle_count;
   logic [63:0] instret_count;
   core_sequencer dut (
      .clk           (clk),
      .rstn          (rstn),
      .bus           (bus_if),
      .cycle_count   (cycle_count),
      .instret_count (instret_count)
   );
`else
   core_sequencer dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        br;
      logic [31:0] tgt;
      logic        trap;
      logic [31:0] tvec;
      logic        mret;
      logic [31:0] mepc;
      int          busy_n;
      logic        halt;
      logic [31:0] exp_pc;
      logic        exp_tt;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      bus_if.start = 1'b1;
      step();
      bus_if.start = 1'b0;
   endtask

   function automatic logic [4:0] strobes();
      return {bus_if.fetch_en, bus_if.decode_en, bus_if.execute_en,
              bus_if.memory_en, bus_if.write_en};
   endfunction

   // Run one instruction from FETCH or DECODE through WRITE with the given vector.
   task automatic run_instr(input vec_t v, input string nm);
      int guard;
      int mcyc;
      guard = 0;
      while (!bus_if.execute_en && guard < 10) begin
         step();
         guard++;
      end
      check({nm, "_reach_exec"}, 64'(bus_if.execute_en), 64'd1);
      bus_if.ex_branch_taken  = v.br;
      bus_if.ex_branch_target = v.tgt;
      bus_if.ex_trap          = v.trap;
      bus_if.trap_vector      = v.tvec;
      bus_if.ex_mret          = v.mret;
      bus_if.mepc             = v.mepc;
      step();
      bus_if.ex_branch_taken  = 1'b0;
      bus_if.ex_branch_target = 32'd0;
      bus_if.ex_trap          = 1'b0;
      bus_if.trap_vector      = 32'd0;
      bus_if.ex_mret          = 1'b0;
      bus_if.mepc             = 32'd0;
      mcyc = 0;
      for (int i = 0; i <= v.busy_n; i++) begin
         if (bus_if.memory_en) mcyc++;
         bus_if.mem_busy = (i < v.busy_n);
         step();
      end
      bus_if.mem_busy = 1'b0;
      check({nm, "_mem_len"}, 64'(mcyc), 64'(v.busy_n + 1));
      check({nm, "_retire"}, 64'(bus_if.retire), 64'd1);
      check({nm, "_trap_taken"}, 64'(bus_if.trap_taken), 64'(v.exp_tt));
      bus_if.halt_req = v.halt;
      step();
      bus_if.halt_req = 1'b0;
      check({nm, "_pc"}, 64'(bus_if.pc), 64'(v.exp_pc));
      check({nm, "_busy"}, 64'(bus_if.busy), 64'(!v.halt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int mcyc;
      logic ret_seen;
      n_cmp = 0;
      n_err = 0;

      //      br    tgt            trap  tvec    mret  mepc    busy halt  exp_pc         tt
      tbl[0]  = '{1'b1, 32'd9,        1'b0, 32'd0,  1'b0, 32'd0,  0, 1'b0, 32'd9,        1'b0};
      tbl[1]  = '{1'b0, 32'd0,        1'b0, 32'd0,  1'b0, 32'd0,  0, 1'b0, 32'd10,       1'b0};
      tbl[2]  = '{1'b1, 32'd9,        1'b0, 32'd0,  1'b0, 32'd0,  0, 1'b0, 32'd9,        1'b0};
      tbl[3]  = '{1'b1, 32'd14,       1'b0, 32'd0,  1'b0, 32'd0,  0, 1'b0, 32'd14,       1'b0};
      tbl[4]  = '{1'b1, 32'd3,        1'b1, 32'd47, 1'b1, 32'd99, 0, 1'b0, 32'd47,       1'b1};
      tbl[5]  = '{1'b0, 32'd0,        1'b0, 32'd0,  1'b1, 32'd5,  0, 1'b0, 32'd5,        1'b0};
      tbl[6]  = '{1'b1, 32'd30,       1'b0, 32'd0,  1'b1, 32'd20, 0, 1'b0, 32'd20,       1'b0};
      tbl[7]  = '{1'b0, 32'd0,        1'b0, 32'd0,  1'b0, 32'd0,  3, 1'b0, 32'd21,       1'b0};
      tbl[8]  = '{1'b1, 32'hFFFFFFFF, 1'b0, 32'd0,  1'b0, 32'd0,  0, 1'b0, 32'hFFFFFFFF, 1'b0};
      tbl[9]  = '{1'b0, 32'd0,        1'b0, 32'd0,  1'b0, 32'd0,  0, 1'b0, 32'd0,        1'b0};
      tbl[10] = '{1'b0, 32'd0,        1'b0, 32'd0,  1'b0, 32'd0,  0, 1'b1, 32'd1,        1'b0};

      bus_if.start            = 1'b0;
      bus_if.halt_req         = 1'b0;
      bus_if.ex_branch_taken  = 1'b0;
      bus_if.ex_branch_target = 32'd0;
      bus_if.ex_trap          = 1'b0;
      bus_if.trap_vector      = 32'd0;
      bus_if.ex_mret          = 1'b0;
      bus_if.mepc             = 32'd0;
      bus_if.mem_busy         = 1'b0;

      // Reset values
      rstn = 1'b0;
      step();
      step();
      check("rst_pc", 64'(bus_if.pc), 64'd0);
      check("rst_busy", 64'(bus_if.busy), 64'd0);
      check("rst_strobes", 64'(strobes()), 64'd0);
      check("rst_retire", 64'(bus_if.retire), 64'd0);
      check("rst_trap_taken", 64'(bus_if.trap_taken), 64'd0);
      check("rst_fault", 64'(bus_if.fault), 64'd0);
      rstn = 1'b1;
      step();
      check("idle_hold", 64'(bus_if.busy), 64'd0);

      // Steady-state: three sequential instructions, cycle by cycle
      do_start();
      for (int c = 1; c <= 15; c++) begin
         check($sformatf("seq_strobe_c%0d", c), 64'(strobes()), 64'(5'b10000 >> ((c - 1) % 5)));
         check($sformatf("seq_retire_c%0d", c), 64'(bus_if.retire), 64'((c % 5) == 0));
         check($sformatf("seq_pc_c%0d", c), 64'(bus_if.pc), 64'((c - 1) / 5));
         step();
      end
      check("seq_pc_after3", 64'(bus_if.pc), 64'd3);

      // Table of redirect / stall / wrap / halt vectors
      for (int k = 0; k < 11; k++) begin
         run_instr(tbl[k], $sformatf("vec%0d", k));
      end

      // Memory timeout: 16 busy cycles -> fault, idle, pc kept, no retire
      do_start();
      step();
      step();
      step();
      check("to_in_mem", 64'(bus_if.memory_en), 64'd1);
      mcyc = 0;
      ret_seen = 1'b0;
      bus_if.mem_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (bus_if.memory_en) mcyc++;
         if (bus_if.retire) ret_seen = 1'b1;
         step();
      end
      bus_if.mem_busy = 1'b0;
      if (bus_if.retire) ret_seen = 1'b1;
      check("to_mem_len", 64'(mcyc), 64'd16);
      check("to_fault", 64'(bus_if.fault), 64'd1);
      check("to_busy", 64'(bus_if.busy), 64'd0);
      check("to_pc", 64'(bus_if.pc), 64'd1);
      check("to_no_retire", 64'(ret_seen), 64'd0);
      step();
      check("to_fault_sticky", 64'(bus_if.fault), 64'd1);
      do_start();
      check("restart_fault_clr", 64'(bus_if.fault), 64'd0);
      check("restart_fetch", 64'(bus_if.fetch_en), 64'd1);
      check("restart_pc", 64'(bus_if.pc), 64'd1);
      run_instr('{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 0, 1'b0, 32'd2, 1'b0}, "refetch");

      // Asynchronous reset in the middle of MEMORY
      step();
      step();
      step();
      check("ar_in_mem", 64'(bus_if.memory_en), 64'd1);
      rstn = 1'b0;
      #1;
      check("ar_busy", 64'(bus_if.busy), 64'd0);
      check("ar_pc", 64'(bus_if.pc), 64'd0);
      check("ar_strobes", 64'(strobes()), 64'd0);
      check("ar_retire", 64'(bus_if.retire), 64'd0);
      step();
      rstn = 1'b1;
      step();
      check("ar_idle_after", 64'(bus_if.busy), 64'd0);

      // halt_req pulse outside WRITE is lost; 3 instructions then halt
      do_start();
      bus_if.halt_req = 1'b1;
      step();
      bus_if.halt_req = 1'b0;
      run_instr('{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 0, 1'b0, 32'd1, 1'b0}, "perf0");
      run_instr('{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 0, 1'b0, 32'd2, 1'b0}, "perf1");
      run_instr('{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 0, 1'b1, 32'd3, 1'b0}, "perf2");
      check("halt_strobes", 64'(strobes()), 64'd0);
`ifdef SEQ_PERF_COUNTERS_EN
      check("perf_instret", instret_count, 64'd3);
      check("perf_cycles", cycle_count, 64'd15);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
